// File: rtl/riscv_pkg.sv
// Shared core definitions used by the fetch controller: widths, PC step and fetch FSM states.
package riscv_pkg;
    localparam int XLEN = 32;
    localparam int ILEN = 32;
    localparam int PC_INC = 4;
    localparam logic [XLEN-1:0] RESET_PC = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        OUT  = 2'd3
    } ifetch_state_t;
endpackage

// File: rtl/ifetch_ctrl_if.sv
// Fetch-side bus bundle: imem request/response, redirect input and decode handshake.
interface ifetch_ctrl_if;
    import riscv_pkg::*;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [ILEN-1:0] imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_target;
    logic            inst_valid;
    logic            inst_ready;
    logic [ILEN-1:0] inst_data;
    logic [XLEN-1:0] inst_pc;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_target,
        output inst_valid, inst_data, inst_pc,
        input  inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_target,
        input  inst_valid, inst_data, inst_pc,
        output inst_ready
    );
endinterface

// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: IDLE/REQ/WAIT/OUT FSM, one instruction per 3 cycles best case.
// IFETCH_MISALIGN_TRAP_EN: misaligned redirects are refused and flagged on fetch_misalign.
module ifetch_ctrl #(
    parameter int XLEN = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] next_pc,
    output logic            pc_en,
    ifetch_ctrl_if.master   bus
`ifdef IFETCH_MISALIGN_TRAP_EN
    ,output logic           fetch_misalign
`endif
);
    import riscv_pkg::*;

    ifetch_state_t   state, state_nxt;
    logic            drop, drop_nxt;
    logic            redir_ok;
    logic [XLEN-1:0] redir_pc;
    logic            req_hs;
    logic            out_hs;

    assign req_hs = bus.imem_req_valid & bus.imem_req_ready;
    assign out_hs = bus.inst_valid & bus.inst_ready;

`ifdef IFETCH_MISALIGN_TRAP_EN
    logic redir_bad;
    assign redir_bad = bus.redirect_valid & (|bus.redirect_target[1:0]);
    assign redir_ok  = bus.redirect_valid & ~redir_bad;
    assign redir_pc  = bus.redirect_target;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) fetch_misalign <= 1'b0;
        else       fetch_misalign <= redir_bad;
    end
`else
    assign redir_ok = bus.redirect_valid;
    assign redir_pc = {bus.redirect_target[XLEN-1:2], 2'b00};
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        drop_nxt  = drop;
        pc_en     = 1'b0;
        next_pc   = pc + XLEN'(PC_INC);
        case (state)
            IDLE: state_nxt = REQ;
            REQ: begin
                // The in-flight address stays on the bus; its response is discarded later.
                if (redir_ok) drop_nxt = 1'b1;
                if (req_hs)   state_nxt = WAIT;
            end
            WAIT: begin
                if (bus.imem_rsp_valid) begin
                    if (drop || redir_ok) begin
                        drop_nxt  = 1'b0;
                        state_nxt = REQ;
                    end else begin
                        state_nxt = OUT;
                    end
                end else if (redir_ok) begin
                    drop_nxt = 1'b1;
                end
            end
            OUT: begin
                if (out_hs) begin
                    pc_en     = 1'b1;
                    next_pc   = bus.inst_pc + XLEN'(PC_INC);
                    state_nxt = REQ;
                end
                if (redir_ok) state_nxt = REQ;
            end
            default: state_nxt = IDLE;
        endcase
        if (redir_ok) begin
            pc_en   = 1'b1;
            next_pc = redir_pc;
        end
        if (!rstn) begin
            pc_en   = 1'b0;
            next_pc = RESET_PC;
        end
    end

    // A PC load in the entry cycle means pc only shows the new value next cycle, so take it from next_pc.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            drop               <= 1'b0;
            bus.imem_req_valid <= 1'b0;
            bus.imem_req_addr  <= '0;
            bus.inst_valid     <= 1'b0;
            bus.inst_data      <= '0;
            bus.inst_pc        <= '0;
        end else begin
            drop               <= drop_nxt;
            bus.imem_req_valid <= (state_nxt == REQ);
            bus.inst_valid     <= (state_nxt == OUT);
            if (state_nxt == REQ && state != REQ)
                bus.imem_req_addr <= pc_en ? next_pc : pc;
            if (state == WAIT && state_nxt == OUT) begin
                bus.inst_data <= bus.imem_rsp_data;
                bus.inst_pc   <= bus.imem_req_addr;
            end
        end
    end
endmodule
